instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of the control unit. Owns the PC and requests

---
 rtl/mips_pkg.sv | 34 +++
 rtl/next_pc_logic.sv | 45 ++++
 rtl/instruction_fetch.sv | 116 +++++++++++
 tb/tb_instruction_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Definitions shared by the fetch stage, control and the register file:
//   opcode and funct encodings, the fetch FSM state encoding and the reset PC.
// -----------------------------------------------------------------------------
package mips_pkg;

   // Primary opcodes, Instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   // R-type funct codes, Instr[5:0]
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;
   localparam logic [5:0] FUNCT_JR  = 6'b001000;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   // Fetch FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      VALID = 2'd3
   } fetch_state_t;

   // PC loaded on reset (word aligned)
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/next_pc_logic.sv
// -----------------------------------------------------------------------------
// next_pc_logic
//   Combinational selection of the PC that follows the instruction currently
//   held in fetch. Jr has priority over a taken beq; otherwise fall through.
//   All arithmetic wraps modulo 2^ADDR_W.
// Ports
//   pc_plus4      in   ADDR_W  pc + 4 of the held instruction
//   branch        in   1       beq in decode
//   zero          in   1       ALU equality result
//   branch_offset in   32      sign-extended immediate, in words
//   jr            in   1       jump-register in decode
//   jr_target     in   ADDR_W  rs value for jr (low two bits discarded)
//   next_pc       out  ADDR_W  selected next PC
// -----------------------------------------------------------------------------
module next_pc_logic #(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc_plus4,
   input  logic              branch,
   input  logic              zero,
   input  logic [31:0]       branch_offset,
   input  logic              jr,
   input  logic [ADDR_W-1:0] jr_target,
   output logic [ADDR_W-1:0] next_pc
);

   logic [ADDR_W-1:0] offset_words;
   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] jr_aligned;

   // Signed cast so a negative word offset sign-extends when ADDR_W > 32.
   assign offset_words  = ADDR_W'($signed(branch_offset));
   assign branch_target = pc_plus4 + (offset_words << 2);
   assign jr_aligned    = jr_target & ~ADDR_W'(3);

   always_comb begin
      // NOTE: assigning a default first means every path drives next_pc, so no latch is inferred.
      next_pc = pc_plus4;
      if (jr)
         next_pc = jr_aligned;
      else if (branch && zero)
         next_pc = branch_target;
   end

endmodule : next_pc_logic

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage feeding the control unit. Owns the PC, requests instructions
//   over a req/ready handshake from a variable-latency memory, holds the word
//   in an instruction register and decodes its fields. The held instruction
//   retires on the first VALID cycle with stall=0, at which point the PC takes
//   the branch / jr / fall-through target.
// Ports
//   clk, rst        clock; synchronous active-high reset
//   imem_req        out  read request (registered)
//   imem_addr       out  read address, always the current pc
//   imem_ready      in   memory accepts request, imem_rdata valid this cycle
//   imem_rdata      in   instruction word
//   stall           in   downstream hold; blocks retirement
//   Branch, Zero, BranchOffset, Jr, JrTarget   redirect inputs from decode
//   Instr           out  instruction register
//   OpCode, Rs, Rt, Rd, Funct, Imm              decoded fields of Instr
//   PcPlus4         out  pc + 4 of the held instruction
//   InstrValid      out  Instr is valid and not yet retired
// -----------------------------------------------------------------------------
module instruction_fetch
   import mips_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(mips_pkg::RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic              Branch,
   input  logic              Zero,
   input  logic [31:0]       BranchOffset,
   input  logic              Jr,
   input  logic [ADDR_W-1:0] JrTarget,
   output logic [31:0]       Instr,
   output logic [5:0]        OpCode,
   output logic [4:0]        Rs,
   output logic [4:0]        Rt,
   output logic [4:0]        Rd,
   output logic [5:0]        Funct,
   output logic [15:0]       Imm,
   output logic [ADDR_W-1:0] PcPlus4,
   output logic              InstrValid
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] next_pc;

   assign imem_addr = pc;
   assign PcPlus4   = pc + ADDR_W'(4);

   assign OpCode = Instr[31:26];
   assign Rs     = Instr[25:21];
   assign Rt     = Instr[20:16];
   assign Rd     = Instr[15:11];
   assign Funct  = Instr[5:0];
   assign Imm    = Instr[15:0];

   next_pc_logic #(.ADDR_W(ADDR_W)) u_next_pc (
      .pc_plus4      (PcPlus4),
      .branch        (Branch),
      .zero          (Zero),
      .branch_offset (BranchOffset),
      .jr            (Jr),
      .jr_target     (JrTarget),
      .next_pc       (next_pc)
   );

   // Redirect inputs are only consulted on the retiring VALID cycle, so any
   // values they carry while stalled have no effect.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking (<=) so every register updates from pre-edge values.
      if (rst) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         Instr      <= '0;
         InstrValid <= 1'b0;
         imem_req   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               state    <= REQ;
               imem_req <= 1'b1;
            end
            REQ, WAIT: begin
               if (imem_ready) begin
                  Instr      <= imem_rdata;
                  InstrValid <= 1'b1;
                  imem_req   <= 1'b0;
                  state      <= VALID;
               end else begin
                  state <= WAIT;
               end
            end
            VALID: begin
               if (!stall) begin
                  pc         <= next_pc;
                  InstrValid <= 1'b0;
                  imem_req   <= 1'b1;
                  state      <= REQ;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        Branch;
   logic        Zero;
   logic [31:0] BranchOffset;
   logic        Jr;
   logic [31:0] JrTarget;
   logic [31:0] Instr;
   logic [5:0]  OpCode;
   logic [4:0]  Rs, Rt, Rd;
   logic [5:0]  Funct;
   logic [15:0] Imm;
   logic [31:0] PcPlus4;
   logic        InstrValid;

   instruction_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .stall        (stall),
      .Branch       (Branch),
      .Zero         (Zero),
      .BranchOffset (BranchOffset),
      .Jr           (Jr),
      .JrTarget     (JrTarget),
      .Instr        (Instr),
      .OpCode       (OpCode),
      .Rs           (Rs),
      .Rt           (Rt),
      .Rd           (Rd),
      .Funct        (Funct),
      .Imm          (Imm),
      .PcPlus4      (PcPlus4),
      .InstrValid   (InstrValid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic        prev_valid = 1'b0;
   logic [31:0] last_addr;
   logic [31:0] last_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: each newly valid instruction is matched against the next
   // expected fetch pushed by the stimulus.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (InstrValid && !prev_valid) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: got instr %h at %h expected none", Instr, imem_addr);
         end else begin
            e = sb_q.pop_front();
            check("sb_addr",    imem_addr,         e.addr);
            check("sb_instr",   Instr,             e.data);
            check("sb_opcode",  32'(OpCode),       32'(e.data[31:26]));
            check("sb_rs",      32'(Rs),           32'(e.data[25:21]));
            check("sb_rt",      32'(Rt),           32'(e.data[20:16]));
            check("sb_rd",      32'(Rd),           32'(e.data[15:11]));
            check("sb_funct",   32'(Funct),        32'(e.data[5:0]));
            check("sb_imm",     32'(Imm),          32'(e.data[15:0]));
            check("sb_pcplus4", PcPlus4,           e.addr + 32'd4);
         end
      end
      prev_valid = InstrValid;
   end

   // Serve one fetch at exp_addr after `waits` not-ready cycles. Entered and
   // left on a falling edge.
   task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data, input int waits);
      int n = 0;
      sb_q.push_back('{addr: exp_addr, data: data});
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", 32'(imem_req), 32'd1);
      check("req_addr", imem_addr, exp_addr);
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         check("wait_req",   32'(imem_req),   32'd1);
         check("wait_addr",  imem_addr,       exp_addr);
         check("wait_valid", 32'(InstrValid), 32'd0);
      end
      imem_ready = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_ready = 1'b0;
      imem_rdata = 32'($urandom);
      check("fetch_valid", 32'(InstrValid), 32'd1);
      check("fetch_req",   32'(imem_req),   32'd0);
      last_addr = exp_addr;
      last_data = data;
   endtask

   // Stall for `stalls` cycles with junk redirect/memory inputs, then retire
   // with the given redirect and check the next request address.
   task automatic retire(input logic br, input logic zr, input logic [31:0] off,
                         input logic jr_i, input logic [31:0] tgt, input int stalls,
                         input logic [31:0] exp_next);
      for (int s = 0; s < stalls; s++) begin
         stall        = 1'b1;
         Branch       = 1'($urandom);
         Zero         = 1'($urandom);
         Jr           = 1'($urandom);
         JrTarget     = 32'($urandom);
         BranchOffset = 32'($urandom);
         imem_ready   = 1'b1;
         imem_rdata   = ~last_data;
         @(negedge clk);
         check("stall_instr", Instr,             last_data);
         check("stall_pc",    imem_addr,         last_addr);
         check("stall_valid", 32'(InstrValid),   32'd1);
         check("stall_req",   32'(imem_req),     32'd0);
      end
      imem_ready   = 1'b0;
      stall        = 1'b0;
      Branch       = br;
      Zero         = zr;
      BranchOffset = off;
      Jr           = jr_i;
      JrTarget     = tgt;
      @(negedge clk);
      Branch = 1'b0; Zero = 1'b0; Jr = 1'b0; BranchOffset = '0; JrTarget = '0;
      check("retire_valid", 32'(InstrValid), 32'd0);
      check("retire_req",   32'(imem_req),   32'd1);
      check("next_addr",    imem_addr,       exp_next);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
      Branch = 1'b0; Zero = 1'b0; BranchOffset = '0; Jr = 1'b0; JrTarget = '0;
      repeat (2) @(negedge clk);
      check("rst_req",   32'(imem_req),   32'd0);
      check("rst_valid", 32'(InstrValid), 32'd0);
      check("rst_instr", Instr,           32'd0);
      check("rst_pc",    imem_addr,       32'd0);
      rst = 1'b0;

      // zero-wait add, then sequential fetch with 3 wait cycles
      fetch(32'h0, 32'h0000_0020, 0);
      retire(0, 0, 32'd0, 0, 32'd0, 0, 32'h4);
      fetch(32'h4, 32'h8C22_0004, 3);
      retire(0, 0, 32'd0, 0, 32'd0, 0, 32'h8);
      // jr with misaligned target -> 0x40
      fetch(32'h8, 32'h03E0_0008, 0);
      retire(0, 0, 32'd0, 1, 32'h42, 0, 32'h40);
      // beq taken, offset -2 -> 0x3C
      fetch(32'h40, 32'h1022_FFFE, 1);
      retire(1, 1, 32'hFFFF_FFFE, 0, 32'd0, 0, 32'h3C);
      fetch(32'h3C, 32'hAC22_0008, 0);
      retire(0, 0, 32'd0, 1, 32'h40, 0, 32'h40);
      // beq not taken -> 0x44
      fetch(32'h40, 32'h1022_FFFE, 0);
      retire(1, 0, 32'hFFFF_FFFE, 0, 32'd0, 0, 32'h44);
      // Jr beats Branch
      fetch(32'h44, 32'h03E0_0008, 2);
      retire(1, 1, 32'd5, 1, 32'h1003, 0, 32'h1000);
      // two stall cycles with toggling redirects; final beq +3 -> 0x1010
      fetch(32'h1000, 32'h1022_0003, 0);
      retire(1, 1, 32'd3, 0, 32'd0, 2, 32'h1010);
      // pc wrap 0xFFFFFFFC -> 0
      fetch(32'h1010, 32'h03E0_0008, 0);
      retire(0, 0, 32'd0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
      fetch(32'hFFFF_FFFC, 32'h2003_0005, 0);
      retire(0, 0, 32'd0, 0, 32'd0, 0, 32'h0);

      // reset while WAIT has a request pending; late ready must be ignored
      imem_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("wrst_req",   32'(imem_req),   32'd0);
      check("wrst_valid", 32'(InstrValid), 32'd0);
      check("wrst_instr", Instr,           32'd0);
      check("wrst_pc",    imem_addr,       32'd0);
      rst        = 1'b0;
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ready = 1'b0;
      check("late_instr", Instr,           32'd0);
      check("late_valid", 32'(InstrValid), 32'd0);
      check("late_req",   32'(imem_req),   32'd1);
      check("late_pc",    imem_addr,       32'd0);
      fetch(32'h0, 32'h3043_000F, 1);
      retire(0, 0, 32'd0, 0, 32'd0, 0, 32'h4);

      @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_instruction_fetch
